// File: rtl/hazard_stall_unit.sv
// Stall, bubble and flush control beside the decode stage of the 5-stage WISC pipeline.
// Optional statistics counters (stat_* ports) are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
    parameter int MISS_TIMEOUT = 64
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_op,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic [3:0]       id_rd,
    input  logic             ex_memread,
    input  logic [3:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             I_stall_d,
    output logic             exBranch_d,
    output logic             miss_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_lu,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_imiss,
    output logic [CNT_W-1:0] stat_dmiss
`endif
);

    localparam int TW = $clog2(MISS_TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BR_FLUSH, I_WAIT, D_WAIT} state_t;

    state_t        state, next_state;
    logic          reads_rs, reads_rt, reads_rd, load_use;
    logic          lu_act, br_act, flush_act, iw_act, dw_act;
    logic [TW-1:0] wait_cnt, wait_inc;
    logic          in_wait, next_in_wait;

    // Which register fields the ID instruction actually reads
    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        reads_rd = 1'b0;
        if (!id_op[3]) begin
            reads_rs = 1'b1;
            reads_rt = (id_op <= 4'd3) || (id_op == 4'd7);
        end else begin
            case (id_op)
                4'b1000:          reads_rs = 1'b1;
                4'b1001:          begin reads_rs = 1'b1; reads_rt = 1'b1; end
                4'b1010, 4'b1011: reads_rd = 1'b1;
                4'b1101:          reads_rs = 1'b1;
                default:          ;
            endcase
        end
    end

    assign load_use = ex_memread && (ex_rd != 4'd0) &&
                      ((reads_rs && (id_rs == ex_rd)) ||
                       (reads_rt && (id_rt == ex_rd)) ||
                       (reads_rd && (id_rd == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dcache_miss)      next_state = D_WAIT;
                else if (ex_br_taken) next_state = BR_FLUSH;
                else if (icache_miss) next_state = I_WAIT;
            end
            BR_FLUSH: next_state = IDLE;
            I_WAIT: begin
                if (dcache_miss)       next_state = D_WAIT;
                else if (ex_br_taken)  next_state = BR_FLUSH;
                else if (icache_ready) next_state = IDLE;
            end
            D_WAIT: begin
                if (dcache_ready) next_state = icache_miss ? I_WAIT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs follow the incoming event in the same cycle; everything is forced low during reset
    always_comb begin
        lu_act    = 1'b0;
        br_act    = 1'b0;
        flush_act = 1'b0;
        iw_act    = 1'b0;
        dw_act    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (dcache_miss)      dw_act = 1'b1;
                    else if (ex_br_taken) br_act = 1'b1;
                    else if (icache_miss) iw_act = 1'b1;
                    else if (load_use)    lu_act = 1'b1;
                end
                BR_FLUSH: flush_act = 1'b1;
                I_WAIT: begin
                    if (dcache_miss)        dw_act = 1'b1;
                    else if (ex_br_taken)   br_act = 1'b1;
                    else if (!icache_ready) iw_act = 1'b1;
                end
                D_WAIT: begin
                    if (!dcache_ready)    dw_act = 1'b1;
                    else if (icache_miss) iw_act = 1'b1;
                end
                default: ;
            endcase
        end
        pc_hold     = dw_act | iw_act | lu_act;
        ifid_hold   = dw_act | iw_act | lu_act;
        ifid_flush  = br_act | flush_act;
        idex_bubble = br_act | iw_act | lu_act;
        exmem_hold  = dw_act;
        I_stall_d   = iw_act | lu_act;
        exBranch_d  = br_act | flush_act;
    end

    // The timeout keeps counting across I_WAIT/D_WAIT hand-offs and clears only when waiting ends
    assign in_wait      = (state == I_WAIT) || (state == D_WAIT);
    assign next_in_wait = (next_state == I_WAIT) || (next_state == D_WAIT);
    assign wait_inc     = wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            miss_err <= 1'b0;
        end else if (in_wait) begin
            if ((MISS_TIMEOUT != 0) && (wait_inc == TW'(MISS_TIMEOUT))) miss_err <= 1'b1;
            if (!next_in_wait)                           wait_cnt <= '0;
            else if (wait_cnt != TW'(MISS_TIMEOUT))      wait_cnt <= wait_inc;
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lu    <= '0;
            stat_br    <= '0;
            stat_imiss <= '0;
            stat_dmiss <= '0;
        end else begin
            if (lu_act && (stat_lu != '1))                   stat_lu    <= stat_lu + 1'b1;
            if ((br_act || flush_act) && (stat_br != '1))    stat_br    <= stat_br + 1'b1;
            if (iw_act && (stat_imiss != '1))                stat_imiss <= stat_imiss + 1'b1;
            if (dw_act && (stat_dmiss != '1))                stat_dmiss <= stat_dmiss + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a default instance plus a MISS_TIMEOUT=8 instance
// whose miss_err is tracked separately.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_op = '0, id_rs = '0, id_rt = '0, id_rd = '0, ex_rd = '0;
    logic       ex_memread = 1'b0, ex_br_taken = 1'b0;
    logic       icache_miss = 1'b0, icache_ready = 1'b0, dcache_miss = 1'b0, dcache_ready = 1'b0;
    logic [7:0] outv, out8;

`ifdef HAZARD_STATS_EN
    logic [15:0] stat_lu, stat_br, stat_imiss, stat_dmiss;
    logic [15:0] stat_lu8, stat_br8, stat_imiss8, stat_dmiss8;
`endif

    // Control bundle: {memread, br_taken, icache_miss, icache_ready, dcache_miss, dcache_ready}
    localparam logic [5:0] C0 = 6'b000000, MR = 6'b100000, BRT = 6'b010000, IM = 6'b001000,
                           IR = 6'b000100, DM = 6'b000010, DR = 6'b000001;
    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, I_stall_d, exBranch_d, miss_err}
    localparam logic [7:0] E_NONE = 8'b0000_0000, E_LU = 8'b1101_0100, E_IW = 8'b1101_0100,
                           E_BR0 = 8'b0011_0010, E_BR1 = 8'b0010_0010, E_DW = 8'b1100_1000;

    typedef struct {
        string      name;
        logic [7:0] exp;
        logic       err8;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .pc_hold(outv[7]), .ifid_hold(outv[6]), .ifid_flush(outv[5]), .idex_bubble(outv[4]),
        .exmem_hold(outv[3]), .I_stall_d(outv[2]), .exBranch_d(outv[1]), .miss_err(outv[0])
`ifdef HAZARD_STATS_EN
        , .stat_lu(stat_lu), .stat_br(stat_br), .stat_imiss(stat_imiss), .stat_dmiss(stat_dmiss)
`endif
    );

    hazard_stall_unit #(.MISS_TIMEOUT(8)) dut_t8 (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .pc_hold(out8[7]), .ifid_hold(out8[6]), .ifid_flush(out8[5]), .idex_bubble(out8[4]),
        .exmem_hold(out8[3]), .I_stall_d(out8[2]), .exBranch_d(out8[1]), .miss_err(out8[0])
`ifdef HAZARD_STATS_EN
        , .stat_lu(stat_lu8), .stat_br(stat_br8), .stat_imiss(stat_imiss8), .stat_dmiss(stat_dmiss8)
`endif
    );

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp_v,
                                input logic act8, input logic exp8);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: outputs actual=%b required=%b", name, act, exp_v);
        end
        checks++;
        if (act8 !== exp8) begin
            errors++;
            $display("[TB] FAIL %s_timeout8: miss_err actual=%b required=%b", name, act8, exp8);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation each falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output(e.name, outv, e.exp, out8[0], e.err8);
        end
    end

    task automatic set_inputs(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                              input logic [3:0] rd, input logic [3:0] er, input logic [5:0] ctl);
        id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_rd = er;
        {ex_memread, ex_br_taken, icache_miss, icache_ready, dcache_miss, dcache_ready} = ctl;
    endtask

    task automatic apply_stimulus(input string name, input logic [7:0] exp_v, input logic exp8,
                                  input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                                  input logic [3:0] rd, input logic [3:0] er, input logic [5:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        set_inputs(op, rs, rt, rd, er, ctl);
        e.name = name; e.exp = exp_v; e.err8 = exp8;
        sb.push_back(e);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);
        rst_n = 1'b1;
    endtask

    // Asserts reset between clock edges so the outputs must drop without waiting for an edge
    task automatic do_reset(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);
        e.name = name; e.exp = E_NONE; e.err8 = 1'b0;
        sb.push_back(e);
        release_reset();
    endtask

    initial begin
        apply_stimulus("reset_outputs", E_NONE, 1'b0, 4'b0000, 4'd3, 4'd5, 4'd4, 4'd3, MR | BRT | IM | DM);
        release_reset();

        apply_stimulus("lu_add_rs",      E_LU,   1'b0, 4'b0000, 4'd3, 4'd5, 4'd4, 4'd3, MR);
        apply_stimulus("lu_after",       E_NONE, 1'b0, 4'b0000, 4'd3, 4'd5, 4'd4, 4'd0, C0);
        apply_stimulus("lu_sub_rt",      E_LU,   1'b0, 4'b0001, 4'd5, 4'd3, 4'd4, 4'd3, MR);
        apply_stimulus("no_lu_sll_rt",   E_NONE, 1'b0, 4'b0100, 4'd1, 4'd3, 4'd4, 4'd3, MR);
        apply_stimulus("no_lu_r0",       E_NONE, 1'b0, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, MR);
        apply_stimulus("no_lu_llb",      E_NONE, 1'b0, 4'b1010, 4'd2, 4'd2, 4'd3, 4'd2, MR);
        apply_stimulus("lu_llb_rd",      E_LU,   1'b0, 4'b1010, 4'd1, 4'd1, 4'd3, 4'd3, MR);
        apply_stimulus("lu_sw_rt",       E_LU,   1'b0, 4'b1001, 4'd1, 4'd7, 4'd2, 4'd7, MR);
        apply_stimulus("no_lu_b",        E_NONE, 1'b0, 4'b1100, 4'd7, 4'd7, 4'd7, 4'd7, MR);
        apply_stimulus("lu_br_rs",       E_LU,   1'b0, 4'b1101, 4'd7, 4'd0, 4'd0, 4'd7, MR);
        apply_stimulus("no_lu_not_load", E_NONE, 1'b0, 4'b0000, 4'd3, 4'd5, 4'd4, 4'd3, C0);

        apply_stimulus("br_taken_lu",    E_BR0,  1'b0, 4'b0000, 4'd3, 4'd5, 4'd4, 4'd3, MR | BRT);
        apply_stimulus("br_flush",       E_BR1,  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);
        apply_stimulus("br_done",        E_NONE, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);

        for (int i = 0; i < 10; i++)
            apply_stimulus($sformatf("imiss_wait_%0d", i), E_IW, (i >= 9), 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("imiss_ready",    E_NONE, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IR);
        apply_stimulus("imiss_after",    E_NONE, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);
        do_reset("reset_clears_err");

        apply_stimulus("prio_dmiss_br",  E_DW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, DM | BRT);
        apply_stimulus("dready_idle",    E_NONE, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, DR);
        apply_stimulus("br_imiss_0",     E_IW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("br_imiss_1",     E_BR0,  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM | BRT);
        apply_stimulus("br_imiss_2",     E_BR1,  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("br_imiss_3",     E_NONE, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);

        apply_stimulus("nest_iw_0",      E_IW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_iw_1",      E_IW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_dmiss",     E_DW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM | DM);
        for (int i = 0; i < 4; i++)
            apply_stimulus($sformatf("nest_dwait_%0d", i), E_DW, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_dready",    E_IW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM | DR);
        apply_stimulus("nest_iw_2",      E_IW,   1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_iw_3",      E_IW,   1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_iw_4",      E_IW,   1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IM);
        apply_stimulus("nest_iready",    E_NONE, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, IR);

        apply_stimulus("dwait_enter",    E_DW,   1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, DM);
        apply_stimulus("dwait_hold",     E_DW,   1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);
        do_reset("reset_mid_dwait");
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        checks++;
        if (stat_dmiss !== 16'd0) begin
            errors++;
            $display("[TB] FAIL stat_dmiss_reset: actual=%0d required=0", stat_dmiss);
        end
`endif
        apply_stimulus("idle_final",     E_NONE, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, C0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
